// File: rtl/fifo_wc_pkg.sv
// Shared constants and helpers for the width-converting FIFO.
// Optional flush support is enabled in the top level by defining FIFO_WC_FLUSH_EN.
package fifo_wc_pkg;

    localparam int FIFO_WC_IN_W  = 8;
    localparam int FIFO_WC_RATIO = 2;
    localparam int FIFO_WC_DEPTH = 32;

    // What the output register does on the coming edge.
    typedef enum logic [1:0] {
        LOAD_NONE,
        LOAD_FULL,
        LOAD_PARTIAL,
        LOAD_DRAIN
    } load_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Low bit of packed word k; word 0 (oldest) lands in the MSBs.
    function automatic int pack_offset(input int in_w, input int ratio, input int k);
        return in_w * (ratio - 1 - k);
    endfunction

endpackage

// File: rtl/fifo_wc_mem.sv
// Storage array for the width-converting FIFO: one write port and RATIO
// asynchronous read ports at consecutive addresses (wrapping modulo DEPTH).
module fifo_wc_mem
    import fifo_wc_pkg::*;
#(
    parameter int W     = FIFO_WC_IN_W,
    parameter int RATIO = FIFO_WC_RATIO,
    parameter int DEPTH = FIFO_WC_DEPTH,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [W-1:0]              wr_data,
    input  logic [AW-1:0]             rd_base,
    output logic [RATIO-1:0][W-1:0]   rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Address arithmetic is AW bits wide, so the window wraps past DEPTH-1 for free.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_rd
        assign rd_data[gi] = mem[rd_base + AW'(gi)];
    end

endmodule

// File: rtl/fifo_width_conv.sv
// Width-converting FIFO: packs RATIO input words (oldest in the MSBs) into one registered output word.
// Define FIFO_WC_FLUSH_EN to add the flush input and out_partial output for zero-padded residual words.
module fifo_width_conv
    import fifo_wc_pkg::*;
#(
    parameter int IN_W  = FIFO_WC_IN_W,
    parameter int RATIO = FIFO_WC_RATIO,
    parameter int DEPTH = FIFO_WC_DEPTH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IN_W*RATIO-1:0]   out_data,
    output logic [clog2(DEPTH):0]   level
`ifdef FIFO_WC_FLUSH_EN
    ,
    input  logic                    flush,
    output logic                    out_partial
`endif
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int OW = IN_W * RATIO;

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] count;
    logic          out_valid_reg, out_valid_next;
    logic [OW-1:0] out_data_reg, out_data_next;
    logic          push;
    logic          out_free;
    logic          flush_hold;
    load_e         load_sel;

    logic [RATIO-1:0][IN_W-1:0] rd_words;
    logic [OW-1:0]              full_word;
    logic [OW-1:0]              partial_word;

    assign count    = wr_ptr_reg - rd_ptr_reg;
    assign in_ready = (count < PW'(DEPTH)) && !flush_hold;
    assign push     = in_valid && in_ready;
    assign out_free = !out_valid_reg || out_ready;

    fifo_wc_mem #(
        .W     (IN_W),
        .RATIO (RATIO),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg[AW-1:0]),
        .wr_data (in_data),
        .rd_base (rd_ptr_reg[AW-1:0]),
        .rd_data (rd_words)
    );

    // Words beyond the residual count are zero-filled for a flushed partial word.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_pack
        assign full_word[pack_offset(IN_W, RATIO, gi) +: IN_W]    = rd_words[gi];
        assign partial_word[pack_offset(IN_W, RATIO, gi) +: IN_W] =
            (PW'(gi) < count) ? rd_words[gi] : '0;
    end

    always_comb begin
        load_sel = LOAD_NONE;
        if (out_free) begin
            if (count >= PW'(RATIO)) begin
                load_sel = LOAD_FULL;
            end else if (flush_hold && (count != '0)) begin
                load_sel = LOAD_PARTIAL;
            end else if (out_valid_reg) begin
                load_sel = LOAD_DRAIN;
            end
        end
    end

    always_comb begin
        wr_ptr_next    = wr_ptr_reg + PW'(push);
        rd_ptr_next    = rd_ptr_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        case (load_sel)
            LOAD_FULL: begin
                rd_ptr_next    = rd_ptr_reg + PW'(RATIO);
                out_valid_next = 1'b1;
                out_data_next  = full_word;
            end
            LOAD_PARTIAL: begin
                rd_ptr_next    = wr_ptr_reg;
                out_valid_next = 1'b1;
                out_data_next  = partial_word;
            end
            LOAD_DRAIN: begin
                out_valid_next = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
        end
    end

`ifdef FIFO_WC_FLUSH_EN
    logic flush_pending_reg, flush_pending_next;
    logic out_partial_reg, out_partial_next;
    logic [PW-1:0] count_after;

    assign flush_hold  = flush_pending_reg;
    assign count_after = wr_ptr_next - rd_ptr_next;

    // Pending stays up until storage has been emptied; a new flush re-arms it.
    always_comb begin
        flush_pending_next = flush || (flush_pending_reg && (count_after != '0));
        out_partial_next   = out_partial_reg;
        if (load_sel == LOAD_FULL) begin
            out_partial_next = 1'b0;
        end else if (load_sel == LOAD_PARTIAL) begin
            out_partial_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flush_pending_reg <= 1'b0;
            out_partial_reg   <= 1'b0;
        end else begin
            flush_pending_reg <= flush_pending_next;
            out_partial_reg   <= out_partial_next;
        end
    end

    assign out_partial = out_partial_reg;
`else
    assign flush_hold = 1'b0;
`endif

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign level     = count;

endmodule

// File: tb/tb_fifo_width_conv.sv
// Randomised and directed bench for fifo_width_conv against a queue-based reference model.
// Flush scenarios are exercised when FIFO_WC_FLUSH_EN is defined.
`timescale 1ns/1ps
module tb_fifo_width_conv;

    localparam int IN_W  = 8;
    localparam int RATIO = 2;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [5:0]  level;
`ifdef FIFO_WC_FLUSH_EN
    logic        out_partial;
    logic        b_out_partial;
`endif

    logic        b_in_valid = 1'b0;
    logic        b_out_ready = 1'b0;
    logic [3:0]  b_in_data = '0;
    logic        b_in_ready;
    logic        b_out_valid;
    logic [15:0] b_out_data;
    logic [4:0]  b_level;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_width_conv #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level)
`ifdef FIFO_WC_FLUSH_EN
        , .flush(flush), .out_partial(out_partial)
`endif
    );

    fifo_width_conv #(.IN_W(4), .RATIO(4), .DEPTH(16)) dut_b (
        .clk(clk), .rstn(rstn),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .level(b_level)
`ifdef FIFO_WC_FLUSH_EN
        , .flush(1'b0), .out_partial(b_out_partial)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus the output register contents.
    logic [7:0]  mq[$];
    bit          m_ov = 1'b0;
    logic [15:0] m_od = '0;
    bit          m_op = 1'b0;
    bit          m_fp = 1'b0;
    logic [15:0] got[$];

    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                mq.delete();
                m_ov = 1'b0;
                m_od = '0;
                m_op = 1'b0;
                m_fp = 1'b0;
            end else begin : upd
                bit free;
                bit acc;
                int n;
                logic [15:0] w;
                if (out_valid && out_ready) got.push_back(out_data);
                free = !m_ov || out_ready;
                acc  = in_valid && (mq.size() < DEPTH) && !m_fp;
                n = 0;
                if (free) begin
                    if (mq.size() >= RATIO) begin
                        n = RATIO;
                        m_op = 1'b0;
                    end else if (m_fp && mq.size() > 0) begin
                        n = mq.size();
                        m_op = 1'b1;
                    end
                    if (n > 0) begin
                        w = '0;
                        for (int k = 0; k < RATIO; k++) begin
                            w = w << IN_W;
                            if (k < n) w[IN_W-1:0] = mq.pop_front();
                        end
                        m_od = w;
                        m_ov = 1'b1;
                    end else begin
                        m_ov = 1'b0;
                    end
                end
                if (acc) mq.push_back(in_data);
                m_fp = flush || (m_fp && mq.size() != 0);
            end
        end
    end

    // Every-cycle comparison of the main instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                chk("cyc_in_ready", in_ready, (mq.size() < DEPTH) && !m_fp);
                chk("cyc_out_valid", out_valid, m_ov);
                chk("cyc_out_data", out_data, m_od);
                chk("cyc_level", level, mq.size());
`ifdef FIFO_WC_FLUSH_EN
                chk("cyc_out_partial", out_partial, m_op);
`endif
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        repeat (2) step();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 16'h0);
        chk("rst_level", level, 6'd0);
        chk("rst_b_out_valid", b_out_valid, 1'b0);
        rstn = 1'b1;
        step();

        // 4-bit words packed four at a time.
        b_in_valid = 1'b1;
        b_in_data = 4'hA; step();
        b_in_data = 4'hB; step();
        b_in_data = 4'hC; step();
        b_in_data = 4'hD; step();
        b_in_valid = 1'b0;
        chk("b_not_yet_valid", b_out_valid, 1'b0);
        chk("b_level4", b_level, 5'd4);
        step();
        chk("b_out_valid", b_out_valid, 1'b1);
        chk("b_out_data", b_out_data, 16'hABCD);
        chk("b_level0", b_level, 5'd0);

        // Back-to-back bytes with the consumer always ready.
        got.delete();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h11; step();
        in_data = 8'h22; step();
        chk("t1_lat_ov0", out_valid, 1'b0);
        in_data = 8'h33; step();
        chk("t1_ov1", out_valid, 1'b1);
        chk("t1_word0", out_data, 16'h1122);
        in_data = 8'h44; step();
        chk("t1_bubble", out_valid, 1'b0);
        in_valid = 1'b0; step();
        chk("t1_word1", out_data, 16'h3344);
        step();
        chk("t1_got", got.size(), 2);

        // Fill with the consumer stalled: 2 bytes in the output register, 32 stored.
        got.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 35; i++) begin
            in_data = 8'(i + 1);
            step();
            if (i == 32) chk("t2_ready_33", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        chk("t2_level_full", level, 6'd32);
        chk("t2_not_ready", in_ready, 1'b0);
        chk("t2_head", out_data, 16'h0102);
        out_ready = 1'b1;
        repeat (20) step();
        chk("t2_count", got.size(), 17);
        if (got.size() == 17) begin
            chk("t2_first", got[0], 16'h0102);
            chk("t2_last", got[16], 16'h2122);
        end

        // 400 bytes streamed continuously: pointers wrap several times.
        got.delete();
        in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            in_data = 8'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("t3_count", got.size(), 200);
        for (int k = 0; k < 200 && k < got.size(); k++) begin
            chk("t3_word", got[k], {8'(2 * k), 8'(2 * k + 1)});
        end

`ifdef FIFO_WC_FLUSH_EN
        // Single residual byte emitted by flush.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h5A; step();
        in_valid = 1'b0;
        flush = 1'b1; step();
        flush = 1'b0;
        chk("fl_ready_low", in_ready, 1'b0);
        step();
        chk("fl_out_valid", out_valid, 1'b1);
        chk("fl_out_data", out_data, 16'h5A00);
        chk("fl_partial", out_partial, 1'b1);
        chk("fl_level", level, 6'd0);
        chk("fl_ready_back", in_ready, 1'b1);
        out_ready = 1'b1;
        step();
`endif

        // Asynchronous reset with 7 stored words and a full output register.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 8'(8'h90 + i);
            step();
        end
        in_valid = 1'b0;
        chk("rs_level7", level, 6'd7);
        chk("rs_ov1", out_valid, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk("rs_async_ov", out_valid, 1'b0);
        chk("rs_async_level", level, 6'd0);
        chk("rs_async_data", out_data, 16'h0);
        step();
        rstn = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h01; step();
        in_data = 8'h02; step();
        in_valid = 1'b0; step();
        chk("rs_after_ov", out_valid, 1'b1);
        chk("rs_after_data", out_data, 16'h0102);
        step();

        // Random traffic: a stall-heavy phase then a flowing phase.
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 1200; c++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = 8'($urandom);
                out_ready = (p == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
`ifdef FIFO_WC_FLUSH_EN
                flush     = ($urandom_range(0, 40) == 0);
`endif
                step();
            end
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (40) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
